// File: rtl/unified_mem_responder.sv
// unified_mem_responder: single-port unified I/D memory shared by fetch and load/store ports.
// Data wins arbitration unless fetch has been starved STARVE_LIM cycles in a row.
module unified_mem_responder #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_LIM = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err
);
    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [31:0]       mem [2**(ADDR_W-2)];
    logic [CW-1:0]     starve_cnt;
    logic              force_if, d_bad;
    logic [31:0]       d_word, ld_data, st_data;
    logic [3:0]        st_be;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [ADDR_W-3:0] if_idx, d_idx;
    logic              unused_bits;

    always_comb begin
        if_idx      = if_addr[ADDR_W-1:2];
        d_idx       = d_addr[ADDR_W-1:2];
        unused_bits = ^{if_addr[31:ADDR_W], if_addr[1:0], d_addr[31:ADDR_W]};
        force_if    = starve_cnt == CW'(STARVE_LIM);
        d_gnt       = d_req & ~force_if;
        if_gnt      = if_req & (~d_req | force_if);
        d_word      = mem[d_idx];
        ld_byte     = d_word[{d_addr[1:0], 3'b000} +: 8];
        ld_half     = d_addr[1] ? d_word[31:16] : d_word[15:0];
        ld_data     = d_funct3 == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
                      d_funct3 == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
                      d_funct3 == 3'b100 ? {24'b0, ld_byte} :
                      d_funct3 == 3'b101 ? {16'b0, ld_half} : d_word;
        // funct3[1:0] 01 = halfword, 10 = word; both carry alignment constraints
        d_bad       = (d_funct3 == 3'b011) | (d_we ? d_funct3[2] : d_funct3[2:1] == 2'b11) |
                      (d_funct3[1:0] == 2'b01 & d_addr[0]) |
                      (d_funct3[1:0] == 2'b10 & |d_addr[1:0]);
        st_be       = d_funct3[1:0] == 2'b00 ? 4'b0001 << d_addr[1:0] :
                      d_funct3[1:0] == 2'b01 ? (d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_data     = d_funct3[1:0] == 2'b00 ? {4{d_wdata[7:0]}} :
                      d_funct3[1:0] == 2'b01 ? {2{d_wdata[15:0]}} : d_wdata;
    end

    always_ff @(posedge clk) begin
        if (d_gnt & d_we & ~d_bad)
            for (int b = 0; b < 4; b++)
                if (st_be[b]) mem[d_idx][8*b +: 8] <= st_data[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            d_err      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            starve_cnt <= (if_gnt | ~if_req) ? '0 : force_if ? starve_cnt : starve_cnt + 1'b1;
            if_valid   <= if_gnt;
            d_valid    <= d_gnt;
            d_err      <= d_gnt & d_bad;
            if (if_gnt) if_rdata <= mem[if_idx];
            if (d_gnt) d_rdata <= (d_we | d_bad) ? '0 : ld_data;
        end
    end
endmodule
